trail_write_arbiter: RTL and testbench
======================================

TRAIL_WRITE_ARBITER -- requirements
Module: trail_write_arbiter

Interface
REQ-001 Parameter CLEAR_WORDS, default 76800: frame-buffer words zeroed by one clear sweep.
REQ-002 Parameter MAX_BURST, default 16: maximum consecutive grant cycles per trail requester.
REQ-003 Clk  in  1  system clock (50 MHz); one clock; all state updates on posedge Clk.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 clear_start  in  1  one-cycle pulse requesting a frame-buffer clear sweep.
REQ-006 blue_req / red_req  in  1 each  trail-writer request, held high for the whole burst.
REQ-007 blue_addr / red_addr  in  20 each  write address from the requester.
REQ-008 blue_data / red_data  in  16 each  write data from the requester.
REQ-009 blue_gnt / red_gnt  out  1 each  grant; a word is written on each cycle where gnt and req are both high.
REQ-010 fb_addr  out  20  frame-buffer write address.
REQ-011 fb_data  out  16  frame-buffer write data.
REQ-012 fb_we  out  1  frame-buffer write enable.
REQ-013 clear_busy  out  1  high while the sweep is pending or running.
REQ-014 clear_done  out  1  one-cycle pulse after the last clear word is written.

Function
REQ-015 FSM states: IDLE, GNT_B, GNT_R, CLEAR; gnt outputs decoded from the registered state only.
REQ-016 In IDLE, priority is: pending clear, then round-robin between blue_req and red_req; the requester not served last wins a tie.
REQ-017 A request seen in IDLE at cycle N moves the FSM to a grant state at N+1; the first write occurs at N+1 if req is still high.
REQ-018 In GNT_x with req_x high: fb_we=1, fb_addr=x_addr, fb_data=x_data, and the burst counter increments.
REQ-019 In GNT_x with req_x low: fb_we=0 and the next state is IDLE; no dead cycles in between.
REQ-020 Write number MAX_BURST in a burst ends the burst, and at the next cycle:
  - a pending clear goes to CLEAR;
  - otherwise, if the other requester is high, go straight to its grant state;
  - otherwise go to IDLE.
REQ-021 Burst counter: 4+ bits wide; cleared on every state entry; never wraps inside one burst.
REQ-022 A clear_start pulse sets a pending flag; clear_busy rises the next cycle.
  - A pulse during GNT_x does not preempt the burst; the clear is taken at the burst boundary.
  - A pulse during CLEAR or while already pending is ignored.
REQ-023 CLEAR writes one word per cycle: fb_we=1, fb_data=16'h0000, fb_addr = clear counter (0 to CLEAR_WORDS-1); both gnt outputs stay low.
REQ-024 After address CLEAR_WORDS-1:
  - clear_done pulses the next cycle;
  - clear_busy drops the same cycle;
  - the FSM returns to IDLE;
  - the clear counter returns to 0.
REQ-025 A clear_start arriving in the same cycle as a requester in IDLE: clear wins.
REQ-026 Outside a write cycle, fb_we=0 and fb_addr/fb_data=0; blue and red are never granted together.

Reset
REQ-027 While Reset=1, on the next edge:
  - state=IDLE;
  - counters=0;
  - pending clear=0;
  - round-robin pointer = blue-next;
  - all outputs=0.
REQ-028 A Reset during a burst or sweep aborts it; no fb_we in the cycle after Reset is sampled.

Structure
REQ-029 The FSM state enum, FB_ADDR_W=20 and FB_DATA_W=16 live in the shared game package (tron_pkg).
REQ-030 The clear sweep counter is a natural sub-module, fb_clear_counter (start, enable, count, last).

Verification
REQ-031 blue_req held 3 cycles from IDLE -> blue_gnt at N+1; three writes with blue addresses; then IDLE.
REQ-032 blue_req and red_req both held 40 cycles, blue served last -> red bursts first; 16-word bursts alternate red/blue; no idle gap.
REQ-033 clear_start pulsed mid blue burst (write 5) -> burst completes to 16 words, then CLEAR writes addresses 0..CLEAR_WORDS-1 with data 0, then one clear_done pulse.
REQ-034 clear_start and red_req in the same IDLE cycle -> CLEAR first; red_gnt only after clear_done.
REQ-035 Reset asserted at clear word 100 -> next cycle fb_we=0 and clear_busy=0; a fresh clear_start restarts the sweep at address 0.
REQ-036 Random req/clear traffic for 10k cycles -> blue_gnt & red_gnt never both high; each fb_we matches exactly one source.

Source files
------------

// File: rtl/tron_pkg.sv
// Shared game package: frame-buffer widths, arbiter state encoding and
// a helper that sizes the per-requester burst counter.
package tron_pkg;

  localparam int FB_ADDR_W = 20;
  localparam int FB_DATA_W = 16;

  // Arbiter FSM: idle, grant to blue, grant to red, frame-buffer clear sweep.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_B = 2'd1,
    GNT_R = 2'd2,
    CLEAR = 2'd3
  } arb_state_t;

  // Burst counter must hold MAX_BURST without wrapping and is never
  // narrower than 4 bits.
  function automatic int burst_cnt_width(input int max_burst);
    int w;
    w = $clog2(max_burst + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/fb_clear_counter.sv
// Address generator for the frame-buffer clear sweep. Counts
// 0..CLEAR_WORDS-1 while enabled, flags the final address, and wraps back
// to 0 after it so the next sweep starts clean.
module fb_clear_counter
  import tron_pkg::*;
#(
  parameter int CLEAR_WORDS = 76800
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 enable,
  output logic [FB_ADDR_W-1:0] count,
  output logic                 last
);

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(CLEAR_WORDS - 1);

  logic [FB_ADDR_W-1:0] count_reg;

  // Sweep address: held at 0 until the sweep runs, then one step per cycle.
  always_ff @(posedge Clk) begin
    if (Reset || start) begin
      count_reg <= '0;
    end else if (enable) begin
      if (count_reg == LAST_ADDR) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == LAST_ADDR);

endmodule

// File: rtl/trail_write_arbiter.sv
// Frame-buffer write arbiter: shares one write port between the blue and
// red trail writers (round-robin, bounded bursts) and a full-screen clear
// sweep that takes priority at burst boundaries.
module trail_write_arbiter
  import tron_pkg::*;
#(
  parameter int CLEAR_WORDS = 76800,
  parameter int MAX_BURST   = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 clear_start,
  input  logic                 blue_req,
  input  logic                 red_req,
  input  logic [FB_ADDR_W-1:0] blue_addr,
  input  logic [FB_ADDR_W-1:0] red_addr,
  input  logic [FB_DATA_W-1:0] blue_data,
  input  logic [FB_DATA_W-1:0] red_data,
  output logic                 blue_gnt,
  output logic                 red_gnt,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [FB_DATA_W-1:0] fb_data,
  output logic                 fb_we,
  output logic                 clear_busy,
  output logic                 clear_done
);

  localparam int BURST_W = burst_cnt_width(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  arb_state_t           state_reg;
  arb_state_t           state_next;
  logic [BURST_W-1:0]   burst_cnt_reg;
  logic                 pending_reg;
  logic                 pending_next;
  logic                 rr_blue_next_reg;
  logic                 clear_done_reg;

  logic                 trail_write;
  logic                 burst_last;
  logic                 clear_wanted;
  logic [FB_ADDR_W-1:0] clr_count;
  logic                 clr_last;

  // Sweep address counter is parked at 0 whenever the FSM is not clearing.
  fb_clear_counter #(
    .CLEAR_WORDS (CLEAR_WORDS)
  ) u_clear_cnt (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (state_reg != CLEAR),
    .enable (state_reg == CLEAR),
    .count  (clr_count),
    .last   (clr_last)
  );

  assign burst_last   = (burst_cnt_reg == BURST_LAST);
  // A pulse on the same cycle counts as pending so a clear is never
  // deferred past the boundary it arrives on.
  assign clear_wanted = pending_reg || clear_start;

  // Next-state and write-port decode from the registered state.
  always_comb begin
    state_next  = state_reg;
    fb_we       = 1'b0;
    fb_addr     = '0;
    fb_data     = '0;
    trail_write = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clear_wanted) begin
          state_next = CLEAR;
        end else if (blue_req && red_req) begin
          state_next = rr_blue_next_reg ? GNT_B : GNT_R;
        end else if (blue_req) begin
          state_next = GNT_B;
        end else if (red_req) begin
          state_next = GNT_R;
        end
      end
      GNT_B: begin
        if (!blue_req) begin
          state_next = IDLE;
        end else begin
          fb_we       = 1'b1;
          fb_addr     = blue_addr;
          fb_data     = blue_data;
          trail_write = 1'b1;
          if (burst_last) begin
            if (clear_wanted)  state_next = CLEAR;
            else if (red_req)  state_next = GNT_R;
            else               state_next = IDLE;
          end
        end
      end
      GNT_R: begin
        if (!red_req) begin
          state_next = IDLE;
        end else begin
          fb_we       = 1'b1;
          fb_addr     = red_addr;
          fb_data     = red_data;
          trail_write = 1'b1;
          if (burst_last) begin
            if (clear_wanted)  state_next = CLEAR;
            else if (blue_req) state_next = GNT_B;
            else               state_next = IDLE;
          end
        end
      end
      CLEAR: begin
        fb_we   = 1'b1;
        fb_addr = clr_count;
        fb_data = '0;
        if (clr_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pending-clear flag: latched outside a sweep, consumed on entry to CLEAR.
  always_comb begin
    pending_next = pending_reg;
    if (state_next == CLEAR) begin
      pending_next = 1'b0;
    end else if (clear_start && (state_reg != CLEAR)) begin
      pending_next = 1'b1;
    end
  end

  // State register, pending flag and clear-done pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= IDLE;
      pending_reg    <= 1'b0;
      clear_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      clear_done_reg <= (state_reg == CLEAR) && clr_last;
    end
  end

  // Burst counter: restarts on every state change, counts accepted writes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      burst_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      burst_cnt_reg <= '0;
    end else if (trail_write) begin
      burst_cnt_reg <= burst_cnt_reg + 1'b1;
    end
  end

  // Round-robin pointer: the requester currently being served yields next tie.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_blue_next_reg <= 1'b1;
    end else if (state_reg == GNT_B) begin
      rr_blue_next_reg <= 1'b0;
    end else if (state_reg == GNT_R) begin
      rr_blue_next_reg <= 1'b1;
    end
  end

  assign blue_gnt   = (state_reg == GNT_B);
  assign red_gnt    = (state_reg == GNT_R);
  assign clear_busy = pending_reg || (state_reg == CLEAR);
  assign clear_done = clear_done_reg;

endmodule

// File: tb/tb_trail_write_arbiter.sv
// Directed bench for trail_write_arbiter with hand-computed expectations,
// followed by randomized traffic checked for grant exclusivity and write
// source consistency.
module tb_trail_write_arbiter;

  localparam int CW = 200;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        clear_start;
  logic        blue_req, red_req;
  logic [19:0] blue_addr, red_addr;
  logic [15:0] blue_data, red_data;
  logic        blue_gnt, red_gnt;
  logic [19:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_we;
  logic        clear_busy, clear_done;

  int n_total = 0;
  int n_bad   = 0;

  trail_write_arbiter #(
    .CLEAR_WORDS (CW),
    .MAX_BURST   (16)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .clear_start (clear_start),
    .blue_req    (blue_req),
    .red_req     (red_req),
    .blue_addr   (blue_addr),
    .red_addr    (red_addr),
    .blue_data   (blue_data),
    .red_data    (red_data),
    .blue_gnt    (blue_gnt),
    .red_gnt     (red_gnt),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done)
  );

  always #10 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic b_ok, r_ok, c_ok;
    logic exp_red;
    Reset = 1'b1; clear_start = 1'b0;
    blue_req = 1'b0; red_req = 1'b0;
    blue_addr = '0; red_addr = '0; blue_data = '0; red_data = '0;

    // Reset state
    cyc(); cyc(); #1;
    check_val("rst_bgnt", 32'(blue_gnt), 0);
    check_val("rst_rgnt", 32'(red_gnt), 0);
    check_val("rst_we", 32'(fb_we), 0);
    check_val("rst_addr", 32'(fb_addr), 0);
    check_val("rst_busy", 32'(clear_busy), 0);
    check_val("rst_done", 32'(clear_done), 0);
    Reset = 1'b0;
    $display("reset done");

    // Short blue burst of three words
    cyc(); blue_req = 1'b1; blue_addr = 20'h00B00; blue_data = 16'hB000; #1;
    check_val("t1_idle_gnt", 32'(blue_gnt), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); blue_addr = 20'h00B00 + 20'(k); blue_data = 16'hB000 + 16'(k); #1;
      check_val("t1_bgnt", 32'(blue_gnt), 1);
      check_val("t1_rgnt", 32'(red_gnt), 0);
      check_val("t1_we", 32'(fb_we), 1);
      check_val("t1_addr", 32'(fb_addr), 32'h00B00 + 32'(k));
      check_val("t1_data", 32'(fb_data), 32'hB000 + 32'(k));
    end
    cyc(); blue_req = 1'b0; #1;
    check_val("t1_drop_we", 32'(fb_we), 0);
    check_val("t1_drop_addr", 32'(fb_addr), 0);
    check_val("t1_drop_gnt", 32'(blue_gnt), 1);
    cyc(); #1;
    check_val("t1_idle_after", 32'(blue_gnt), 0);
    $display("blue short burst done");

    // Both requesting for 40 cycles, blue served last
    cyc(); blue_req = 1'b1; red_req = 1'b1;
    blue_addr = 20'h0B000; red_addr = 20'h0A000; blue_data = 16'h1000; red_data = 16'h2000; #1;
    check_val("t2_idle_b", 32'(blue_gnt), 0);
    check_val("t2_idle_r", 32'(red_gnt), 0);
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 40) begin blue_req = 1'b0; red_req = 1'b0; end
      blue_addr = 20'h0B000 + 20'(i); red_addr = 20'h0A000 + 20'(i);
      blue_data = 16'h1000 + 16'(i); red_data = 16'h2000 + 16'(i);
      #1;
      if (i < 40) begin
        exp_red = (((i - 1) / 16) % 2) == 0;
        check_val("t2_rgnt", 32'(red_gnt), 32'(exp_red));
        check_val("t2_bgnt", 32'(blue_gnt), 32'(!exp_red));
        check_val("t2_we", 32'(fb_we), 1);
        check_val("t2_addr", 32'(fb_addr), exp_red ? 32'h0A000 + 32'(i) : 32'h0B000 + 32'(i));
        check_val("t2_data", 32'(fb_data), exp_red ? 32'h2000 + 32'(i) : 32'h1000 + 32'(i));
      end else begin
        check_val("t2_end_rgnt", 32'(red_gnt), 1);
        check_val("t2_end_we", 32'(fb_we), 0);
      end
    end
    cyc(); #1;
    check_val("t2_idle_end", 32'(blue_gnt | red_gnt), 0);
    $display("alternating bursts done");

    // Clear pulse at write 5 of a blue burst
    cyc(); blue_req = 1'b1; blue_addr = 20'h0C000; blue_data = 16'hC000; #1;
    check_val("t3_idle_gnt", 32'(blue_gnt), 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(); blue_addr = 20'h0C000 + 20'(i); blue_data = 16'hC000 + 16'(i);
      clear_start = (i == 5); #1;
      check_val("t3_bgnt", 32'(blue_gnt), 1);
      check_val("t3_we", 32'(fb_we), 1);
      check_val("t3_addr", 32'(fb_addr), 32'h0C000 + 32'(i));
      check_val("t3_busy", 32'(clear_busy), 32'(i >= 6));
    end
    for (int j = 0; j < CW; j++) begin
      cyc(); clear_start = 1'b0; #1;
      check_val("t3_clr_we", 32'(fb_we), 1);
      check_val("t3_clr_addr", 32'(fb_addr), 32'(j));
      check_val("t3_clr_data", 32'(fb_data), 0);
      check_val("t3_clr_gnt", 32'(blue_gnt | red_gnt), 0);
      check_val("t3_clr_busy", 32'(clear_busy), 1);
      check_val("t3_clr_done", 32'(clear_done), 0);
    end
    cyc(); blue_req = 1'b0; #1;
    check_val("t3_done", 32'(clear_done), 1);
    check_val("t3_done_busy", 32'(clear_busy), 0);
    check_val("t3_done_we", 32'(fb_we), 0);
    cyc(); #1;
    check_val("t3_done_pulse", 32'(clear_done), 0);
    check_val("t3_after_gnt", 32'(blue_gnt), 0);
    $display("clear during burst done");

    // Clear and red request on the same idle cycle
    cyc(); clear_start = 1'b1; red_req = 1'b1; red_addr = 20'h0D000; red_data = 16'hD000; #1;
    check_val("t4_idle_rgnt", 32'(red_gnt), 0);
    for (int j = 0; j < CW; j++) begin
      cyc(); clear_start = 1'b0; #1;
      check_val("t4_clr_addr", 32'(fb_addr), 32'(j));
      check_val("t4_clr_we", 32'(fb_we), 1);
      check_val("t4_clr_rgnt", 32'(red_gnt), 0);
      check_val("t4_clr_busy", 32'(clear_busy), 1);
    end
    cyc(); #1;
    check_val("t4_done", 32'(clear_done), 1);
    check_val("t4_done_rgnt", 32'(red_gnt), 0);
    cyc(); #1;
    check_val("t4_rgnt", 32'(red_gnt), 1);
    check_val("t4_we", 32'(fb_we), 1);
    check_val("t4_addr", 32'(fb_addr), 32'h0D000);
    check_val("t4_done_clr", 32'(clear_done), 0);
    cyc(); red_req = 1'b0; #1;
    check_val("t4_drop_we", 32'(fb_we), 0);
    cyc(); #1;
    check_val("t4_idle", 32'(red_gnt), 0);
    $display("clear beats red done");

    // Reset in the middle of a sweep
    cyc(); clear_start = 1'b1; #1;
    for (int j = 0; j <= 100; j++) begin
      cyc(); clear_start = 1'b0; #1;
      check_val("t5_addr", 32'(fb_addr), 32'(j));
      if (j == 100) Reset = 1'b1;
    end
    cyc(); Reset = 1'b0; #1;
    check_val("t5_rst_we", 32'(fb_we), 0);
    check_val("t5_rst_busy", 32'(clear_busy), 0);
    check_val("t5_rst_done", 32'(clear_done), 0);
    cyc(); clear_start = 1'b1; #1;
    check_val("t5_idle_busy", 32'(clear_busy), 0);
    cyc(); clear_start = 1'b0; #1;
    check_val("t5_re_addr0", 32'(fb_addr), 0);
    check_val("t5_re_we", 32'(fb_we), 1);
    check_val("t5_re_busy", 32'(clear_busy), 1);
    cyc(); #1;
    check_val("t5_re_addr1", 32'(fb_addr), 1);
    Reset = 1'b1;
    cyc(); cyc(); Reset = 1'b0;
    $display("reset mid sweep done");

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      cyc();
      blue_req    = ($urandom_range(0, 3) != 0);
      red_req     = ($urandom_range(0, 3) != 0);
      clear_start = ($urandom_range(0, 299) == 0);
      blue_addr   = 20'($urandom);
      red_addr    = 20'($urandom);
      blue_data   = 16'($urandom);
      red_data    = 16'($urandom);
      #1;
      check_val("rnd_excl", 32'(blue_gnt & red_gnt), 0);
      b_ok = blue_gnt && blue_req && (fb_addr == blue_addr) && (fb_data == blue_data);
      r_ok = red_gnt && red_req && (fb_addr == red_addr) && (fb_data == red_data);
      c_ok = !blue_gnt && !red_gnt && clear_busy && (fb_data == 16'h0000);
      if (fb_we) begin
        check_val("rnd_src", 32'(b_ok) + 32'(r_ok) + 32'(c_ok), 1);
      end else begin
        check_val("rnd_idle_bus", {12'h0, fb_addr} | {16'h0, fb_data}, 0);
      end
    end
    $display("random traffic done");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
